imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe_if.sv | 25 ++
 rtl/imm_gen_pipe.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction in, decoded immediate out.
// The DUT takes the slave modport; the producer/consumer side takes master.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_type;
  logic            out_illegal;
  logic [31:0]     out_instr;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_illegal, out_instr
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_illegal, out_instr
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a 2-entry (main + skid) output buffer.
// Define IMM_GEN_PIPE_CSR_IMM_EN to decode CSR zimm forms of the SYSTEM opcode.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_gen_pipe_if.slave    bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_CSR  = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            illegal;
    logic [31:0]     instr;
  } ent_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  state_e           state_q, state_d;
  ent_t             main_q, main_d, skid_q, skid_d, dec;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      imm32;
  logic             in_xfer, out_xfer;

  // ---------------- decode ----------------
  always_comb begin
    dec         = '0;
    dec.instr   = bus.in_instr;
    dec.typ     = T_NONE;
    dec.illegal = 1'b0;
    case (bus.in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: dec.typ = T_I;
      7'b0011011: if (XLEN == 64) dec.typ = T_I; else dec.illegal = 1'b1;
      7'b0100011: dec.typ = T_S;
      7'b1100011: dec.typ = T_B;
      7'b0110111, 7'b0010111: dec.typ = T_U;
      7'b1101111: dec.typ = T_J;
      7'b0110011: dec.typ = T_NONE;
      7'b0111011: if (XLEN != 64) dec.illegal = 1'b1;
`ifdef IMM_GEN_PIPE_CSR_IMM_EN
      7'b1110011: dec.typ = bus.in_instr[14] && (bus.in_instr[13:12] != 2'b00) ? T_CSR : T_I;
`else
      7'b1110011: dec.typ = T_I;
`endif
      default:    dec.illegal = 1'b1;
    endcase

    case (dec.typ)
      T_I:     imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      T_S:     imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
      T_B:     imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[7], bus.in_instr[30:25],
                        bus.in_instr[11:8], 1'b0};
      T_U:     imm32 = {bus.in_instr[31:12], 12'b0};
      T_J:     imm32 = {{12{bus.in_instr[31]}}, bus.in_instr[19:12], bus.in_instr[20],
                        bus.in_instr[30:21], 1'b0};
      T_CSR:   imm32 = {27'b0, bus.in_instr[19:15]};
      default: imm32 = '0;
    endcase
    // Every field is already sign-extended to 32 bits; widen from bit 31.
    dec.imm       = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
  end

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = (state_q != S_EMPTY) & bus.out_ready;

  // ---------------- state / data registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      cnt_q      <= cnt_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: if (in_xfer) begin
        state_d = S_ONE;
        main_d  = dec;
      end
      S_ONE: begin
        if (in_xfer && !out_xfer) begin
          state_d = S_TWO;
          skid_d  = dec;
        end else if (!in_xfer && out_xfer) begin
          state_d = S_EMPTY;
        end else if (in_xfer && out_xfer) begin
          main_d  = dec;
        end
      end
      S_TWO: if (out_xfer) begin
        state_d = S_ONE;
        main_d  = skid_q;
      end
      default: state_d = S_EMPTY;
    endcase
    // Registered ready: deasserts only once both entries are occupied.
    in_ready_d = (state_d != S_TWO);

    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (in_xfer && dec.illegal && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // ---------------- outputs ----------------
  always_comb begin
    bus.in_ready    = in_ready_q;
    bus.out_valid   = (state_q != S_EMPTY);
    bus.out_imm     = main_q.imm;
    bus.out_type    = main_q.typ;
    bus.out_illegal = main_q.illegal;
    bus.out_instr   = main_q.instr;
    illegal_cnt     = cnt_q;
  end

endmodule
